// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - instruction sequencer: program counter, multi-cycle stall, halt and watchdog
`timescale 1ns/1ps
module exec_sequencer #(
  parameter int INSTR_BIT = 6,
  parameter int MAX_INSTR = 1000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 St,
  input  logic                 jump,
  input  logic                 PC_src,
  input  logic [INSTR_BIT-1:0] jump_addr,
  input  logic                 halt,
  input  logic [2:0]           lat,
  output logic [INSTR_BIT-1:0] pc,
  output logic                 wr_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          instr_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, STALL, HALT} state_t;

  localparam logic [31:0] MAX_U = 32'(MAX_INSTR);

  state_t               state, state_nx;
  logic [INSTR_BIT-1:0] pc_nx, br_addr, br_addr_nx, target;
  logic                 br_take, br_take_nx, take;
  logic [2:0]           stall_cnt, stall_cnt_nx;
  logic [15:0]          cnt_nx, cnt_inc;
  logic                 err_nx, retire, wd_hit;

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    cnt_nx       = instr_cnt;
    stall_cnt_nx = stall_cnt;
    br_take_nx   = br_take;
    br_addr_nx   = br_addr;
    err_nx       = err;
    retire       = 1'b0;
    take         = PC_src & jump;
    target       = jump_addr;
    cnt_inc      = (instr_cnt == 16'hFFFF) ? instr_cnt : instr_cnt + 16'd1;
    wd_hit       = (32'(instr_cnt) + 32'd1) == MAX_U;

    case (state)
      IDLE, HALT: begin
        if (St) begin
          state_nx     = RUN;
          pc_nx        = '0;
          cnt_nx       = '0;
          stall_cnt_nx = '0;
          err_nx       = 1'b0;
        end
      end
      RUN: begin
        if (halt) begin
          state_nx = HALT;
        end else if (lat == 3'd0) begin
          retire = 1'b1;
        end else begin
          // Branch decision is captured now; decoder inputs are ignored while stalled
          stall_cnt_nx = lat;
          br_take_nx   = PC_src & jump;
          br_addr_nx   = jump_addr;
          state_nx     = STALL;
        end
      end
      STALL: begin
        take   = br_take;
        target = br_addr;
        if (stall_cnt == 3'd1) retire = 1'b1;
        else stall_cnt_nx = stall_cnt - 3'd1;
      end
      default: state_nx = IDLE;
    endcase

    if (retire) begin
      pc_nx        = take ? target : pc + 1'b1;
      cnt_nx       = cnt_inc;
      stall_cnt_nx = '0;
      state_nx     = wd_hit ? HALT : RUN;
      err_nx       = err | wd_hit;
    end

    wr_en = retire & ~RST;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      pc        <= '0;
      instr_cnt <= '0;
      stall_cnt <= '0;
      br_take   <= 1'b0;
      br_addr   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      instr_cnt <= cnt_nx;
      stall_cnt <= stall_cnt_nx;
      br_take   <= br_take_nx;
      br_addr   <= br_addr_nx;
      err       <= err_nx;
    end
  end

  assign busy = (state == RUN) || (state == STALL);
  assign done = (state == HALT);

endmodule
